// File: rtl/bus_master_ctrl.sv
// Single-outstanding bus master: decodes a slave from the command address,
// drives one bus transaction and returns the response or an error.
module bus_master_ctrl #(
    parameter int NUM_SLAVES = 3,
    parameter int SEL_BITS   = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_mode,
    input  logic [15:0]             cmd_addr,
    input  logic [7:0]              cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              rsp_rdata,
    output logic                    rsp_err,
    output logic                    mode,
    output logic [15:0]             addr,
    output logic [7:0]              wdata,
    output logic                    m_valid,
    output logic [NUM_SLAVES-1:0]   sl_select,
    input  logic [8*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]   s_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic                    mode_nx;
    logic [15:0]             addr_nx;
    logic [7:0]              wdata_nx;
    logic [NUM_SLAVES-1:0]   sel_nx;
    logic [7:0]              rdata_nx;
    logic                    err_nx;

    logic [SEL_BITS-1:0]     cmd_idx;
    logic [NUM_SLAVES-1:0]   cmd_sel;
    logic                    sel_valid;
    logic [7:0]              sel_rdata;

    assign cmd_idx   = cmd_addr[15 -: SEL_BITS];
    assign cmd_ready = (state == IDLE);
    assign m_valid   = (state == REQ);
    assign rsp_valid = (state == RESP);

    // Out-of-range indices give an all-zero select, which flags a decode error.
    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cmd_sel[i] = (cmd_idx == SEL_BITS'(i));
        end
    end

    // Only the selected slave can complete the transaction.
    always_comb begin
        sel_valid = |(s_valid & sl_select);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sl_select[i]) begin
                sel_rdata = sel_rdata | s_rdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;
        addr_nx  = addr;
        wdata_nx = wdata;
        sel_nx   = sl_select;
        rdata_nx = rsp_rdata;
        err_nx   = rsp_err;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    mode_nx  = cmd_mode;
                    addr_nx  = cmd_addr;
                    wdata_nx = cmd_wdata;
                    sel_nx   = cmd_sel;
                    if (|cmd_sel) begin
                        state_nx = REQ;
                    end else begin
                        rdata_nx = '0;
                        err_nx   = 1'b1;
                        state_nx = RESP;
                    end
                end
            end
            REQ: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (sel_valid) begin
                    rdata_nx = sel_rdata;
                    err_nx   = 1'b0;
                    sel_nx   = '0;
                    state_nx = RESP;
                end else if (cnt == CNT_LAST) begin
                    rdata_nx = '0;
                    err_nx   = 1'b1;
                    sel_nx   = '0;
                    state_nx = RESP;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            sl_select <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mode      <= mode_nx;
            addr      <= addr_nx;
            wdata     <= wdata_nx;
            sl_select <= sel_nx;
            rsp_rdata <= rdata_nx;
            rsp_err   <= err_nx;
        end
    end

endmodule
